// File: rtl/reg_file.sv
// Architectural register file with rename status: absorbs ROB commits, records
// dispatcher rename tags, and answers two source-operand queries per cycle.
module reg_file #(
  parameter int ROB_ID_W = 4,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback_signal,
  input  logic                res_rdy_from_rob,
  input  logic [4:0]          regidx_from_rob,
  input  logic [XLEN-1:0]     res_from_rob,
  input  logic [ROB_ID_W-1:0] alias_from_rob,
  input  logic                instr_rdy_from_dsp,
  input  logic [4:0]          rd_from_dsp,
  input  logic [ROB_ID_W-1:0] renameid_from_dsp,
  input  logic [4:0]          rs1_from_dsp,
  input  logic [4:0]          rs2_from_dsp,
  output logic                busy_i_2dsp,
  output logic                busy_j_2dsp,
  output logic [ROB_ID_W-1:0] Qi_2dsp,
  output logic [ROB_ID_W-1:0] Qj_2dsp,
  output logic [XLEN-1:0]     Vi_2dsp,
  output logic [XLEN-1:0]     Vj_2dsp
);

  localparam int QW = 1 + ROB_ID_W + XLEN;

  logic [XLEN-1:0]     r_val  [32];
  logic [ROB_ID_W-1:0] r_tag  [32];
  logic [31:0]         r_busy;

  // Commit presence ignores rdy so the combinational bypass works while paused.
  logic w_commit_any;
  logic w_commit;
  logic w_commit_match;
  logic w_rename;

  assign w_commit_any   = res_rdy_from_rob && (regidx_from_rob != 5'd0);
  assign w_commit       = rdy && w_commit_any;
  assign w_commit_match = r_busy[regidx_from_rob] &&
                          (r_tag[regidx_from_rob] == alias_from_rob);
  assign w_rename       = rdy && instr_rdy_from_dsp && (rd_from_dsp != 5'd0) &&
                          !rollback_signal;

  // x0 is never written (index 0 is excluded above), so it stays at its reset zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
      r_busy <= '0;
    end else if (rdy) begin
      if (w_commit) begin
        r_val[regidx_from_rob] <= res_from_rob;
      end
      if (rollback_signal) begin
        for (int i = 0; i < 32; i++) begin
          r_tag[i] <= '0;
        end
        r_busy <= '0;
      end else begin
        if (w_commit && w_commit_match) begin
          r_busy[regidx_from_rob] <= 1'b0;
          r_tag[regidx_from_rob]  <= '0;
        end
        // Placed last so a same-register rename overrides the commit's clear.
        if (w_rename) begin
          r_busy[rd_from_dsp] <= 1'b1;
          r_tag[rd_from_dsp]  <= renameid_from_dsp;
        end
      end
    end
  end

  // Returns {busy, Q, V} for one source operand.
  function automatic logic [QW-1:0] query(input logic [4:0] rs);
    logic [QW-1:0] res;
    res = '0;
    if (rs == 5'd0) begin
      res = '0;
    end else if (w_commit_any && (regidx_from_rob == rs) && r_busy[rs] &&
                 (alias_from_rob == r_tag[rs])) begin
      res = {1'b0, {ROB_ID_W{1'b0}}, res_from_rob};
    end else if (r_busy[rs]) begin
      res = {1'b1, r_tag[rs], r_val[rs]};
    end else begin
      res = {1'b0, {ROB_ID_W{1'b0}}, r_val[rs]};
    end
    return res;
  endfunction

  assign {busy_i_2dsp, Qi_2dsp, Vi_2dsp} = query(rs1_from_dsp);
  assign {busy_j_2dsp, Qj_2dsp, Vj_2dsp} = query(rs2_from_dsp);

endmodule
